// File: rtl/sc_regbank_write_arbiter_pkg.sv
// Shared definitions for the register-bank write arbiter: FSM encodings,
// the hard-wired zero register address and default sizing.
package sc_regbank_write_arbiter_pkg;

  typedef enum logic {
    STATE_IDLE  = 1'b0,
    STATE_WRITE = 1'b1
  } arb_state_e;

  localparam int ZERO_REG_ADDR     = 0;
  localparam int DEF_NUM_REQ       = 4;
  localparam int DEF_DATAWIDTH_BUS = 32;
  localparam int DEF_ADDRWIDTH_BUS = 5;

endpackage

// File: rtl/sc_rr_picker.sv
// Combinational round-robin picker: scans the request vector starting one
// position after the last winner and returns the first set request as both
// a one-hot vector and a binary index.
module sc_rr_picker #(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  onehot_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  // Rotating priority scan: ptr+1, ptr+2, ... wrapping at N.
  always_comb begin
    logic          found_s;
    logic [IW-1:0] cand_s;
    found_s  = 1'b0;
    cand_s   = {IW{1'b0}};
    onehot_o = {N{1'b0}};
    idx_o    = {IW{1'b0}};
    for (int k = 1; k <= N; k++) begin
      cand_s = IW'((int'(ptr_i) + k) % N);
      if (!found_s && req_i[cand_s]) begin
        found_s          = 1'b1;
        idx_o            = cand_s;
        onehot_o[cand_s] = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
    any_o = found_s;
  end

endmodule

// File: rtl/sc_regbank_write_arbiter.sv
// Round-robin arbiter sharing the single write port of the general register
// bank between NUM_REQ requesters. Each grant produces one registered write
// strobe; a locked owner may stream back-to-back beats. Writes to the zero
// register are acknowledged but never strobe the bank.
module sc_regbank_write_arbiter
  import sc_regbank_write_arbiter_pkg::*;
#(
  parameter int DATAWIDTH_BUS = DEF_DATAWIDTH_BUS,
  parameter int ADDRWIDTH_BUS = DEF_ADDRWIDTH_BUS,
  parameter int NUM_REQ       = DEF_NUM_REQ
) (
  input  logic                               SC_RegBankArb_CLOCK_50,
  input  logic                               SC_RegBankArb_RESET_InHigh,
  input  logic [NUM_REQ-1:0]                 SC_RegBankArb_Req_In,
  input  logic [NUM_REQ-1:0]                 SC_RegBankArb_Lock_In,
  input  logic [NUM_REQ*ADDRWIDTH_BUS-1:0]   SC_RegBankArb_Addr_In,
  input  logic [NUM_REQ*DATAWIDTH_BUS-1:0]   SC_RegBankArb_Data_In,
  output logic [NUM_REQ-1:0]                 SC_RegBankArb_Ack_Out,
  output logic [NUM_REQ-1:0]                 SC_RegBankArb_Grant_Out,
  output logic                               SC_RegBankArb_WrEn_Out,
  output logic [ADDRWIDTH_BUS-1:0]           SC_RegBankArb_WrAddr_Out,
  output logic [DATAWIDTH_BUS-1:0]           SC_RegBankArb_WrData_Out,
  output logic                               SC_RegBankArb_Busy_Out
);

  localparam int IW = $clog2(NUM_REQ);

  arb_state_e               state_q, state_d;
  logic [IW-1:0]            ptr_q, ptr_d;
  logic [NUM_REQ-1:0]       ack_q, ack_d;
  logic [NUM_REQ-1:0]       grant_q, grant_d;
  logic                     wren_q, wren_d;
  logic [ADDRWIDTH_BUS-1:0] wraddr_q, wraddr_d;
  logic [DATAWIDTH_BUS-1:0] wrdata_q, wrdata_d;
  logic                     busy_q, busy_d;

  logic [NUM_REQ-1:0]       win_onehot_s;
  logic [IW-1:0]            win_idx_s;
  logic                     any_req_s;
  logic [IW-1:0]            sel_idx_s;
  logic [NUM_REQ-1:0]       sel_onehot_s;
  logic [ADDRWIDTH_BUS-1:0] sel_addr_s;
  logic [DATAWIDTH_BUS-1:0] sel_data_s;
  logic                     owner_keeps_s;

  sc_rr_picker #(
    .N (NUM_REQ)
  ) u_picker (
    .req_i    (SC_RegBankArb_Req_In),
    .ptr_i    (ptr_q),
    .onehot_o (win_onehot_s),
    .idx_o    (win_idx_s),
    .any_o    (any_req_s)
  );

  // Beat source: the fresh winner when idle, the current owner (ptr) while writing.
  always_comb begin
    if (state_q == STATE_WRITE) begin
      sel_idx_s    = ptr_q;
      sel_onehot_s = {{(NUM_REQ-1){1'b0}}, 1'b1} << ptr_q;
    end else begin
      sel_idx_s    = win_idx_s;
      sel_onehot_s = win_onehot_s;
    end
    sel_addr_s    = SC_RegBankArb_Addr_In[int'(sel_idx_s)*ADDRWIDTH_BUS +: ADDRWIDTH_BUS];
    sel_data_s    = SC_RegBankArb_Data_In[int'(sel_idx_s)*DATAWIDTH_BUS +: DATAWIDTH_BUS];
    owner_keeps_s = SC_RegBankArb_Lock_In[ptr_q] & SC_RegBankArb_Req_In[ptr_q];
  end

  // Next-state and next-output logic; outputs describe the cycle being entered.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    ack_d    = {NUM_REQ{1'b0}};
    grant_d  = {NUM_REQ{1'b0}};
    wren_d   = 1'b0;
    wraddr_d = {ADDRWIDTH_BUS{1'b0}};
    wrdata_d = {DATAWIDTH_BUS{1'b0}};
    busy_d   = 1'b0;
    case (state_q)
      STATE_IDLE: begin
        if (any_req_s) begin
          state_d  = STATE_WRITE;
          ptr_d    = win_idx_s;
          ack_d    = sel_onehot_s;
          grant_d  = sel_onehot_s;
          busy_d   = 1'b1;
          wraddr_d = sel_addr_s;
          wrdata_d = sel_data_s;
          wren_d   = (sel_addr_s != ADDRWIDTH_BUS'(ZERO_REG_ADDR));
        end else begin
          state_d = STATE_IDLE;
        end
      end
      STATE_WRITE: begin
        if (owner_keeps_s) begin
          state_d  = STATE_WRITE;
          ack_d    = sel_onehot_s;
          grant_d  = sel_onehot_s;
          busy_d   = 1'b1;
          wraddr_d = sel_addr_s;
          wrdata_d = sel_data_s;
          wren_d   = (sel_addr_s != ADDRWIDTH_BUS'(ZERO_REG_ADDR));
        end else begin
          state_d = STATE_IDLE;
        end
      end
      default: begin
        state_d = STATE_IDLE;
      end
    endcase
  end

  // State, pointer and registered outputs with synchronous reset.
  always_ff @(posedge SC_RegBankArb_CLOCK_50) begin
    if (SC_RegBankArb_RESET_InHigh) begin
      state_q  <= STATE_IDLE;
      ptr_q    <= IW'(NUM_REQ - 1);
      ack_q    <= {NUM_REQ{1'b0}};
      grant_q  <= {NUM_REQ{1'b0}};
      wren_q   <= 1'b0;
      wraddr_q <= {ADDRWIDTH_BUS{1'b0}};
      wrdata_q <= {DATAWIDTH_BUS{1'b0}};
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      ack_q    <= ack_d;
      grant_q  <= grant_d;
      wren_q   <= wren_d;
      wraddr_q <= wraddr_d;
      wrdata_q <= wrdata_d;
      busy_q   <= busy_d;
    end
  end

  assign SC_RegBankArb_Ack_Out    = ack_q;
  assign SC_RegBankArb_Grant_Out  = grant_q;
  assign SC_RegBankArb_WrEn_Out   = wren_q;
  assign SC_RegBankArb_WrAddr_Out = wraddr_q;
  assign SC_RegBankArb_WrData_Out = wrdata_q;
  assign SC_RegBankArb_Busy_Out   = busy_q;

endmodule

// File: tb/tb_sc_regbank_write_arbiter.sv
// Directed bench for the register-bank write arbiter (NUM_REQ=4).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_sc_regbank_write_arbiter;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 4;

  logic            clk;
  logic            rst;
  logic [NR-1:0]   req;
  logic [NR-1:0]   lock;
  logic [NR*AW-1:0] addr;
  logic [NR*DW-1:0] data;
  logic [NR-1:0]   ack;
  logic [NR-1:0]   grant;
  logic            wren;
  logic [AW-1:0]   wraddr;
  logic [DW-1:0]   wrdata;
  logic            busy;

  int err_cnt = 0;
  int chk_cnt = 0;

  sc_regbank_write_arbiter #(
    .DATAWIDTH_BUS (DW),
    .ADDRWIDTH_BUS (AW),
    .NUM_REQ       (NR)
  ) dut (
    .SC_RegBankArb_CLOCK_50     (clk),
    .SC_RegBankArb_RESET_InHigh (rst),
    .SC_RegBankArb_Req_In       (req),
    .SC_RegBankArb_Lock_In      (lock),
    .SC_RegBankArb_Addr_In      (addr),
    .SC_RegBankArb_Data_In      (data),
    .SC_RegBankArb_Ack_Out      (ack),
    .SC_RegBankArb_Grant_Out    (grant),
    .SC_RegBankArb_WrEn_Out     (wren),
    .SC_RegBankArb_WrAddr_Out   (wraddr),
    .SC_RegBankArb_WrData_Out   (wrdata),
    .SC_RegBankArb_Busy_Out     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_beat(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    addr[i*AW +: AW] = a;
    data[i*DW +: DW] = d;
  endtask

  task automatic chk_quiet(input string tag);
    chk_eq({tag, ".ack"},    64'(ack),    64'd0);
    chk_eq({tag, ".grant"},  64'(grant),  64'd0);
    chk_eq({tag, ".wren"},   64'(wren),   64'd0);
    chk_eq({tag, ".wraddr"}, 64'(wraddr), 64'd0);
    chk_eq({tag, ".wrdata"}, 64'(wrdata), 64'd0);
    chk_eq({tag, ".busy"},   64'(busy),   64'd0);
  endtask

  task automatic chk_write(input string tag, input logic [NR-1:0] oh, input logic en,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
    chk_eq({tag, ".ack"},    64'(ack),    64'(oh));
    chk_eq({tag, ".grant"},  64'(grant),  64'(oh));
    chk_eq({tag, ".wren"},   64'(wren),   64'(en));
    chk_eq({tag, ".wraddr"}, 64'(wraddr), 64'(a));
    chk_eq({tag, ".wrdata"}, 64'(wrdata), 64'(d));
    chk_eq({tag, ".busy"},   64'(busy),   64'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 4'b0000;
    lock = 4'b0000;
    tick();
    tick();
    rst = 1'b0;
  endtask

  logic [NR-1:0] rr_order [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

  initial begin
    rst  = 1'b1;
    req  = 4'b0000;
    lock = 4'b0000;
    addr = '0;
    data = '0;

    // Reset state
    do_reset();
    chk_quiet("reset");

    // 1: single write from requester 0
    set_beat(0, 5'd5, 32'hDEADBEEF);
    req = 4'b0001;
    tick();
    chk_write("t1.wr", 4'b0001, 1'b1, 5'd5, 32'hDEADBEEF);
    req = 4'b0000;
    tick();
    chk_quiet("t1.idle");

    // 2: all four requesting; rotation 0,1,2,3,0, one write per two cycles
    do_reset();
    for (int i = 0; i < NR; i++) set_beat(i, AW'(10 + i), 32'hA000_0000 + DW'(i));
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_eq($sformatf("t2.ack%0d", i), 64'(ack), 64'(rr_order[i]));
      chk_eq($sformatf("t2.wren%0d", i), 64'(wren), 64'd1);
      req = 4'b1111 & ~rr_order[i];
      tick();
      chk_eq($sformatf("t2.gap_ack%0d", i), 64'(ack), 64'd0);
      chk_eq($sformatf("t2.gap_busy%0d", i), 64'(busy), 64'd0);
      req = (i == 4) ? 4'b0000 : 4'b1111;
    end

    // 3: locked 3-beat burst from requester 2 while requester 1 waits
    set_beat(2, 5'd7, 32'h0000_0007);
    set_beat(1, 5'd3, 32'h1111_0003);
    req  = 4'b0100;
    lock = 4'b0100;
    tick();
    chk_write("t3.b0", 4'b0100, 1'b1, 5'd7, 32'h0000_0007);
    set_beat(2, 5'd8, 32'h0000_0008);
    req = 4'b0110;
    tick();
    chk_write("t3.b1", 4'b0100, 1'b1, 5'd8, 32'h0000_0008);
    set_beat(2, 5'd9, 32'h0000_0009);
    tick();
    chk_write("t3.b2", 4'b0100, 1'b1, 5'd9, 32'h0000_0009);
    req  = 4'b0010;
    lock = 4'b0000;
    tick();
    chk_quiet("t3.idle");
    tick();
    chk_write("t3.r1", 4'b0010, 1'b1, 5'd3, 32'h1111_0003);
    req = 4'b0000;
    tick();
    chk_quiet("t3.end");

    // 4: zero-register write is acked without a strobe
    set_beat(3, 5'd0, 32'h12345678);
    req = 4'b1000;
    tick();
    chk_write("t4.zero", 4'b1000, 1'b0, 5'd0, 32'h12345678);
    req = 4'b0000;
    tick();
    chk_quiet("t4.idle");

    // 5: reset during a write cycle aborts it; pointer back to NUM_REQ-1
    set_beat(0, 5'd4, 32'hCAFE_0004);
    req = 4'b0001;
    tick();
    chk_write("t5.wr", 4'b0001, 1'b1, 5'd4, 32'hCAFE_0004);
    rst = 1'b1;
    req = 4'b0000;
    tick();
    chk_quiet("t5.rst");
    rst = 1'b0;
    set_beat(1, 5'd21, 32'hB0B0_0001);
    set_beat(2, 5'd22, 32'hB0B0_0002);
    req = 4'b0110;
    tick();
    chk_write("t5.first", 4'b0010, 1'b1, 5'd21, 32'hB0B0_0001);
    req = 4'b0000;
    tick();
    chk_quiet("t5.idle");

    // 6: requester 0 alone, toggled every other cycle, always served
    for (int i = 0; i < 4; i++) begin
      set_beat(0, AW'(1 + i), 32'h0F00_0000 + DW'(i));
      req = 4'b0001;
      tick();
      chk_write($sformatf("t6.w%0d", i), 4'b0001, 1'b1, AW'(1 + i), 32'h0F00_0000 + DW'(i));
      req = 4'b0000;
      tick();
      chk_eq($sformatf("t6.gap%0d", i), 64'(ack), 64'd0);
    end

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
